// File: rtl/ramp_ctrl_pkg.sv
// ramp_ctrl shared types and defaults.
// Imported by the controller, its timer and the counter-side interface.
package ramp_ctrl_pkg;

    localparam int WIDTH_DEF   = 5;
    localparam int DWELL_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RAMP_UP,
        S_DWELL_HI,
        S_RAMP_DN,
        S_DWELL_LO,
        S_DONE
    } ramp_state_t;

endpackage

// File: rtl/ramp_ctrl_if.sv
// Command/status bundle between ramp_ctrl and the counter datapath.
// master = sequencer, slave = counter.
interface ramp_ctrl_if #(
    parameter int WIDTH = 5
);

    logic [WIDTH-1:0] cnt_value;
    logic             cnt_h_flag;
    logic             cnt_l_flag;
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_load;
    logic             cnt_up;
    logic             cnt_down;

    modport master (
        input  cnt_value, cnt_h_flag, cnt_l_flag,
        output cnt_in, cnt_load, cnt_up, cnt_down
    );

    modport slave (
        output cnt_value, cnt_h_flag, cnt_l_flag,
        input  cnt_in, cnt_load, cnt_up, cnt_down
    );

endinterface

// File: rtl/dwell_timer.sv
// Loadable down-counter timing both dwell phases.
// zero is high when the count has run out.
module dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;

    // load wins over decrement; the count holds at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ramp_ctrl.sv
// Ramp sequencer: load lo, ramp to hi, dwell, ramp down, dwell, repeat.
// Drives an external saturating counter through ramp_ctrl_if.
module ramp_ctrl
    import ramp_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [DWELL_W-1:0] cycles,
    ramp_ctrl_if.master        cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    ramp_state_t        state_q, state_d;
    logic [WIDTH-1:0]   lo_lat, hi_lat;
    logic [DWELL_W-1:0] dwell_lat, cycles_lat;
    logic [DWELL_W-1:0] trip_q, trip_nxt;
    logic               tmr_load, tmr_en, tmr_zero;
    logic               trip_inc;
    logic               load_c, up_c, down_c;
    logic               idle_start;

    assign idle_start = (state_q == S_IDLE) && start && !stop;
    assign trip_nxt   = trip_q + DWELL_W'(1);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (dwell_lat),
        .zero     (tmr_zero)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state, counter commands and status
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        up_c     = 1'b0;
        down_c   = 1'b0;
        done     = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        trip_inc = 1'b0;
        busy     = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (idle_start && lo_bound <= hi_bound)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                load_c  = 1'b1;
                state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                up_c = (cnt.cnt_value < hi_lat) && !cnt.cnt_h_flag;
                if (cnt.cnt_value == hi_lat) begin
                    tmr_load = 1'b1;
                    state_d  = S_DWELL_HI;
                end
            end
            S_DWELL_HI: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_d = S_RAMP_DN;
            end
            S_RAMP_DN: begin
                down_c = (cnt.cnt_value > lo_lat) && !cnt.cnt_l_flag;
                if (cnt.cnt_value == lo_lat) begin
                    tmr_load = 1'b1;
                    state_d  = S_DWELL_LO;
                end
            end
            S_DWELL_LO: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    trip_inc = 1'b1;
                    if (cycles_lat != '0 && trip_nxt == cycles_lat)
                        state_d = S_DONE;
                    else
                        state_d = S_RAMP_UP;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // abort: drop commands this cycle, back to IDLE at the edge
        if (stop && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            load_c   = 1'b0;
            up_c     = 1'b0;
            down_c   = 1'b0;
            done     = 1'b0;
            tmr_load = 1'b0;
            trip_inc = 1'b0;
        end
    end

    // parameter latches, trip counter and start-reject pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_lat     <= '0;
            hi_lat     <= '0;
            dwell_lat  <= '0;
            cycles_lat <= '0;
            trip_q     <= '0;
            err        <= 1'b0;
        end else begin
            err <= idle_start && (lo_bound > hi_bound);
            if (idle_start && lo_bound <= hi_bound) begin
                lo_lat     <= lo_bound;
                hi_lat     <= hi_bound;
                dwell_lat  <= dwell;
                cycles_lat <= cycles;
            end
            if (state_q == S_LOAD) trip_q <= '0;
            else if (trip_inc)     trip_q <= trip_nxt;
        end
    end

    assign cnt.cnt_in   = lo_lat;
    assign cnt.cnt_load = load_c;
    assign cnt.cnt_up   = up_c;
    assign cnt.cnt_down = down_c;

endmodule
